// File: rtl/hack_pkg.sv
// hack_pkg: shared types for the Hack CPU core.
//   state_t    - control FSM states (HALT exists only with HACK_CPU_HALT_DET_EN)
//   I_*        - bit positions of the C-instruction fields
//   alu_ctrl_t - {zx,nx,zy,ny,f,no}, laid out to match instr[11:6]
//   jump_cond  - evaluates the {lt,eq,gt} jump mask against ALU flags
// Optional feature macro: HACK_CPU_HALT_DET_EN
package hack_pkg;

`ifdef HACK_CPU_HALT_DET_EN
    typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, HALT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1} state_t;
`endif

    localparam int I_TYPE    = 15;
    localparam int I_A       = 12;
    localparam int I_COMP_HI = 11;
    localparam int I_COMP_LO = 6;
    localparam int I_DEST_HI = 5;
    localparam int I_DEST_LO = 3;
    localparam int I_JMP_HI  = 2;

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

    // jmp = {lt,eq,gt}; "gt" means strictly positive (neither negative nor zero)
    function automatic logic jump_cond(input logic [2:0] jmp, input logic zr, input logic ng);
        return (jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr);
    endfunction

endpackage

// File: rtl/hack_cpu_if.sv
// hack_cpu_if: memory-side bus of the Hack CPU.
//   instr     - ROM read data (synchronous ROM, one cycle after pc)
//   in_m      - RAM read data (combinational read of address_m)
//   pc        - instruction address
//   address_m - data address
//   out_m     - RAM write data (zero when not writing)
//   write_m   - RAM write strobe
// master = CPU side, slave = memory side.
interface hack_cpu_if #(parameter int PC_W = 15);
    logic [15:0]     instr;
    logic [15:0]     in_m;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] address_m;
    logic [15:0]     out_m;
    logic            write_m;

    modport master (input instr, input in_m,
                    output pc, output address_m, output out_m, output write_m);
    modport slave  (output instr, output in_m,
                    input pc, input address_m, input out_m, input write_m);
endinterface

// File: rtl/hack_cpu_alu.sv
// alu: the standard Hack ALU, purely combinational.
//   x, y - 16-bit operands
//   ctrl - {zx,nx,zy,ny,f,no}
//   out  - result (modulo 2^16)
//   zr   - out == 0
//   ng   - out is negative (bit 15)
module alu
    import hack_pkg::*;
(
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  alu_ctrl_t   ctrl,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);
    logic [15:0] x_z, x_n, y_z, y_n, f_o;

    always_comb begin
        x_z = ctrl.zx ? 16'h0000 : x;
        x_n = ctrl.nx ? ~x_z : x_z;
        y_z = ctrl.zy ? 16'h0000 : y;
        y_n = ctrl.ny ? ~y_z : y_z;
        f_o = ctrl.f ? (x_n + y_n) : (x_n & y_n);
        out = ctrl.no ? ~f_o : f_o;
        zr  = (out == 16'h0000);
        ng  = out[15];
    end
endmodule

// File: rtl/hack_cpu.sv
// hack_cpu: two-phase Hack CPU core (CPI = 2).
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - hack_cpu_if.master: instr/in_m in, pc/address_m/out_m/write_m out
//   halted     - halt-loop detected (only with HACK_CPU_HALT_DET_EN)
// FETCH presents pc while the synchronous ROM reads; EXEC sees a valid
// instr, drives the ALU and write strobe, and commits A/D/pc on its closing
// edge. Everything read during EXEC is the pre-instruction register state,
// so jumps and memory addresses use the old A.
// With HACK_CPU_HALT_DET_EN, an unconditional jump straight back to the
// A-instruction that immediately preceded it parks the core in HALT.
module hack_cpu
    import hack_pkg::*;
#(
    parameter int PC_W = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    hack_cpu_if.master bus
`ifdef HACK_CPU_HALT_DET_EN
    ,
    output logic       halted
`endif
);
    state_t          state, state_nxt;
    logic [15:0]     a_reg, d_reg;
    logic [PC_W-1:0] pc_reg, pc_nxt;

    // Decode
    logic        c_instr;
    alu_ctrl_t   ctrl;
    logic        dest_a, dest_d, dest_m;
    logic [2:0]  jmp;
    logic [15:0] alu_y, alu_out;
    logic        zr, ng;
    logic        take;
    logic        write_m;
    logic        halt_trig;

    assign c_instr = bus.instr[I_TYPE];
    assign ctrl    = alu_ctrl_t'(bus.instr[I_COMP_HI:I_COMP_LO]);
    assign dest_a  = bus.instr[I_DEST_HI];
    assign dest_d  = bus.instr[I_DEST_HI-1];
    assign dest_m  = bus.instr[I_DEST_LO];
    assign jmp     = bus.instr[I_JMP_HI:0];
    assign alu_y   = bus.instr[I_A] ? bus.in_m : a_reg;

    alu u_alu (
        .x    (d_reg),
        .y    (alu_y),
        .ctrl (ctrl),
        .out  (alu_out),
        .zr   (zr),
        .ng   (ng)
    );

    assign take   = c_instr & jump_cond(jmp, zr, ng);
    // pc increment wraps naturally at PC_W bits
    assign pc_nxt = take ? a_reg[PC_W-1:0] : pc_reg + PC_W'(1);

`ifdef HACK_CPU_HALT_DET_EN
    logic [PC_W-1:0] prev_a_pc;
    logic            prev_was_a;

    // Remember where the last A-instruction lived and whether it was the
    // instruction just retired; a self-loop is "@here-1; 0;JMP".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_a_pc  <= '0;
            prev_was_a <= 1'b0;
        end else if (state == EXEC) begin
            prev_was_a <= ~c_instr;
            if (!c_instr) prev_a_pc <= pc_reg;
        end
    end

    assign halt_trig = c_instr & (jmp == 3'b111) & prev_was_a
                       & (a_reg[PC_W-1:0] == prev_a_pc);
    assign halted    = (state == HALT);
`else
    assign halt_trig = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_nxt;
    end

    // FSM next-state and strobe; write_m is combinational from state so an
    // asynchronous reset drops it immediately.
    always_comb begin
        state_nxt = state;
        write_m   = 1'b0;
        case (state)
            FETCH: state_nxt = EXEC;
            EXEC: begin
                write_m = c_instr & dest_m;
`ifdef HACK_CPU_HALT_DET_EN
                state_nxt = halt_trig ? HALT : FETCH;
`else
                state_nxt = FETCH;
`endif
            end
`ifdef HACK_CPU_HALT_DET_EN
            HALT: state_nxt = HALT;
`endif
            default: state_nxt = FETCH;
        endcase
    end

    // Architectural registers commit only on the closing edge of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg  <= 16'h0000;
            d_reg  <= 16'h0000;
            pc_reg <= '0;
        end else if (state == EXEC) begin
            if (!c_instr)    a_reg <= bus.instr;
            else if (dest_a) a_reg <= alu_out;
            if (c_instr && dest_d) d_reg <= alu_out;
            pc_reg <= pc_nxt;
        end
    end

    assign bus.pc        = pc_reg;
    assign bus.address_m = a_reg[PC_W-1:0];
    assign bus.write_m   = write_m;
    assign bus.out_m     = write_m ? alu_out : 16'h0000;

    // halt_trig only steers the FSM when the detector is built in
    logic unused_ok;
    assign unused_ok = halt_trig;
endmodule

// File: tb/tb_hack_cpu.sv
// tb_hack_cpu: directed self-checking bench for hack_cpu.
// Models a synchronous ROM and a combinational-read RAM around the core;
// each task loads a small program, resets, and checks pc/bus outputs at
// FETCH and EXEC phases (sampled on the falling edge).
// Also covers HACK_CPU_HALT_DET_EN when that macro is defined.
module tb_hack_cpu;
    localparam int PC_W  = 15;
    localparam int DEPTH = 1 << PC_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hack_cpu_if #(.PC_W(PC_W)) bus ();

    logic [15:0] rom [0:DEPTH-1];
    logic [15:0] ram [0:DEPTH-1];
    int errors = 0;
    int checks = 0;

`ifdef HACK_CPU_HALT_DET_EN
    logic halted;
`endif

    hack_cpu #(.PC_W(PC_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus)
`ifdef HACK_CPU_HALT_DET_EN
        ,
        .halted (halted)
`endif
    );

    always @(posedge clk) bus.instr <= rom[bus.pc];
    assign bus.in_m = ram[bus.address_m];
    always @(posedge clk) if (bus.write_m) ram[bus.address_m] <= bus.out_m;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < DEPTH; i++) begin
            rom[i] = 16'h0000;
            ram[i] = 16'h0000;
        end
    endtask

    // Leaves the bench at a falling edge with the core in FETCH of pc=0
    task automatic start();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_mem();
        rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'h0003; rom[3] = 16'hE308;
        start();
        for (int i = 0; i < 7; i++) step();
        checks++;
        if (bus.write_m !== 1'b1) begin
            errors++; $display("FAIL reset_pre_write: write_m=%b want 1", bus.write_m);
        end
        // assert reset mid-EXEC, away from any edge
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.write_m !== 1'b0) begin
            errors++; $display("FAIL reset_async_write: write_m=%b want 0", bus.write_m);
        end
        checks++;
        if (bus.out_m !== 16'h0000) begin
            errors++; $display("FAIL reset_out_m: out_m=%h want 0000", bus.out_m);
        end
        checks++;
        if (bus.pc !== 15'd0 || bus.address_m !== 15'd0) begin
            errors++; $display("FAIL reset_regs: pc=%h address_m=%h want 0 0", bus.pc, bus.address_m);
        end
`ifdef HACK_CPU_HALT_DET_EN
        checks++;
        if (halted !== 1'b0) begin
            errors++; $display("FAIL reset_halted: halted=%b want 0", halted);
        end
`endif
        // new program reveals D after reset: M=D must store 0
        rom[0] = 16'h0003; rom[1] = 16'hE308; rom[2] = 16'h0000; rom[3] = 16'h0000;
        @(negedge clk);
        checks++;
        if (ram[3] !== 16'h0000) begin
            errors++; $display("FAIL reset_no_store: ram[3]=%h want 0000", ram[3]);
        end
        rst_n = 1'b1;
        checks++;
        if (bus.pc !== 15'd0) begin
            errors++; $display("FAIL reset_pc_fetch: pc=%h want 0", bus.pc);
        end
        step();
        checks++;
        if (bus.pc !== 15'd0 || bus.address_m !== 15'd0 || bus.write_m !== 1'b0) begin
            errors++; $display("FAIL reset_pc_exec: pc=%h address_m=%h write_m=%b want 0 0 0",
                               bus.pc, bus.address_m, bus.write_m);
        end
        step(); step();
        checks++;
        if (bus.write_m !== 1'b1 || bus.out_m !== 16'h0000 || bus.address_m !== 15'd3) begin
            errors++; $display("FAIL reset_d_zero: write_m=%b out_m=%h address_m=%h want 1 0000 3",
                               bus.write_m, bus.out_m, bus.address_m);
        end
    endtask

    task automatic test_store();
        clear_mem();
        rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'h0007; rom[3] = 16'hE308;
        start();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.pc !== 15'(k)) begin
                errors++; $display("FAIL store_pc_fetch%0d: pc=%h want %h", k, bus.pc, k);
            end
            step();
            checks++;
            if (bus.pc !== 15'(k)) begin
                errors++; $display("FAIL store_pc_exec%0d: pc=%h want %h", k, bus.pc, k);
            end
            if (k < 3) begin
                checks++;
                if (bus.write_m !== 1'b0 || bus.out_m !== 16'h0000) begin
                    errors++; $display("FAIL store_idle%0d: write_m=%b out_m=%h want 0 0000",
                                       k, bus.write_m, bus.out_m);
                end
            end else begin
                checks++;
                if (bus.write_m !== 1'b1 || bus.address_m !== 15'd7 || bus.out_m !== 16'h0005) begin
                    errors++; $display("FAIL store_write: write_m=%b address_m=%h out_m=%h want 1 7 0005",
                                       bus.write_m, bus.address_m, bus.out_m);
                end
            end
            step();
        end
        checks++;
        if (ram[7] !== 16'h0005) begin
            errors++; $display("FAIL store_ram: ram[7]=%h want 0005", ram[7]);
        end
        checks++;
        if (bus.write_m !== 1'b0) begin
            errors++; $display("FAIL store_one_cycle: write_m=%b want 0", bus.write_m);
        end
    endtask

    task automatic test_jump_lt();
        logic [15:0] first [2];
        logic [14:0] want [2];
        first[0] = 16'hEE90; want[0] = 15'd10;  // D=-1 -> JLT taken
        first[1] = 16'hEA90; want[1] = 15'd3;   // D=0  -> JLT not taken
        for (int r = 0; r < 2; r++) begin
            clear_mem();
            rom[0] = first[r]; rom[1] = 16'h000A; rom[2] = 16'hE304;
            start();
            for (int i = 0; i < 5; i++) step();
            checks++;
            if (bus.write_m !== 1'b0 || bus.out_m !== 16'h0000) begin
                errors++; $display("FAIL jlt_nowrite%0d: write_m=%b out_m=%h want 0 0000",
                                   r, bus.write_m, bus.out_m);
            end
            step();
            checks++;
            if (bus.pc !== want[r]) begin
                errors++; $display("FAIL jlt_pc%0d: pc=%h want %h", r, bus.pc, want[r]);
            end
        end
    endtask

    task automatic test_jmp_old_a();
        clear_mem();
        rom[0] = 16'h0014; rom[1] = 16'hEDE7;  // A=A+1;JMP jumps to the old A
        start();
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (bus.pc !== 15'd20 || bus.address_m !== 15'd21) begin
            errors++; $display("FAIL jmp_old_a: pc=%h address_m=%h want 14 15", bus.pc, bus.address_m);
        end
    endtask

    task automatic test_pc_wrap();
        clear_mem();
        rom[0] = 16'h7FFF; rom[1] = 16'hEA87;
        start();
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (bus.pc !== 15'h7FFF) begin
            errors++; $display("FAIL wrap_top: pc=%h want 7fff", bus.pc);
        end
        step(); step();
        checks++;
        if (bus.pc !== 15'd0 || bus.address_m !== 15'd0) begin
            errors++; $display("FAIL wrap_zero: pc=%h address_m=%h want 0 0", bus.pc, bus.address_m);
        end
    endtask

    task automatic test_halt_loop();
        clear_mem();
        rom[4] = 16'h0004; rom[5] = 16'hEA87;
        start();
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (bus.pc !== 15'd4) begin
            errors++; $display("FAIL loop_pc4: pc=%h want 4", bus.pc);
        end
        step(); step();
        checks++;
        if (bus.pc !== 15'd5) begin
            errors++; $display("FAIL loop_pc5: pc=%h want 5", bus.pc);
        end
        step(); step();
        checks++;
        if (bus.pc !== 15'd4) begin
            errors++; $display("FAIL loop_back: pc=%h want 4", bus.pc);
        end
`ifdef HACK_CPU_HALT_DET_EN
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (halted !== 1'b1 || bus.pc !== 15'd4 || bus.write_m !== 1'b0) begin
                errors++; $display("FAIL halt_hold%0d: halted=%b pc=%h write_m=%b want 1 4 0",
                                   i, halted, bus.pc, bus.write_m);
            end
            step();
        end
`else
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.pc !== 15'd4 || bus.write_m !== 1'b0) begin
                errors++; $display("FAIL loop_exec4_%0d: pc=%h write_m=%b want 4 0", i, bus.pc, bus.write_m);
            end
            step();
            checks++;
            if (bus.pc !== 15'd5) begin
                errors++; $display("FAIL loop_fetch5_%0d: pc=%h want 5", i, bus.pc);
            end
            step(); step();
            checks++;
            if (bus.pc !== 15'd4) begin
                errors++; $display("FAIL loop_fetch4_%0d: pc=%h want 4", i, bus.pc);
            end
        end
`endif
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_store();
        test_jump_lt();
        test_jmp_old_a();
        test_pc_wrap();
        test_halt_loop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
